// File: rtl/dac_write_controller_pkg.sv
// Shared definitions for the DAC serial write controller: frame geometry,
// FSM state encoding and the command-word to frame packing helper.
package dac_write_controller_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int PD_BITS    = 2;
    localparam int CMD_BITS   = PD_BITS + DATA_BITS;
    localparam int STATE_BITS = 3;

    localparam logic [FRAME_BITS-CMD_BITS-1:0] FRAME_PAD = '0;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_SYNC_HIGH = 3'd3
    } state_t;

    // Frame layout on the wire, MSB first: {pad, pd[1:0], code[11:0]}.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [CMD_BITS-1:0] cmd);
        return {FRAME_PAD, cmd};
    endfunction

endpackage

// File: rtl/dac_write_controller.sv
// Serial write controller for a DACxx1S101-class DAC: pops one command word
// per frame from a FIFO and shifts a 16-bit frame out on SYNC_n/SCLK/DIN.
module dac_write_controller
    import dac_write_controller_pkg::*;
#(
    parameter int SYNC_HIGH_COUNTS = 2,
    parameter int TIMER_BITS       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [CMD_BITS-1:0] fifo_read_data,
    output logic                fifo_read_enable,
    output logic                dac_write_done,
    output logic                dac_busy,
    output logic                sclk,
    output logic                sync_n,
    output logic                din
);

    localparam logic [TIMER_BITS-1:0] LAST_EDGE  = TIMER_BITS'(FRAME_BITS);
    localparam logic [TIMER_BITS-1:0] LAST_GUARD = TIMER_BITS'(SYNC_HIGH_COUNTS - 1);
    localparam logic [TIMER_BITS-1:0] TIMER_ONE  = TIMER_BITS'(1);

    state_t                  state, state_d;
    logic [FRAME_BITS-1:0]   shift_reg, shift_d;
    logic [TIMER_BITS-1:0]   timer, timer_d;
    logic                    read_enable_d;
    logic                    done_d;
    logic                    busy_d;
    logic                    sclk_d;
    logic                    sync_n_d;
    logic                    din_d;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an incomplete assignment here would infer a latch.
    always_comb begin
        state_d       = state;
        shift_d       = shift_reg;
        timer_d       = timer;
        read_enable_d = 1'b0;
        done_d        = 1'b0;
        sclk_d        = sclk;
        sync_n_d      = sync_n;
        din_d         = din;

        case (state)
            ST_IDLE: begin
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                din_d    = 1'b0;
                if (fifo_read_enable) begin
                    state_d = ST_FETCH;
                    timer_d = '0;
                end else begin
                    read_enable_d = enable && !fifo_empty;
                end
            end

            ST_FETCH: begin
                shift_d  = build_frame(fifo_read_data);
                sync_n_d = 1'b0;
                sclk_d   = 1'b1;
                din_d    = shift_d[FRAME_BITS-1];
                state_d  = ST_SHIFT;
                timer_d  = '0;
            end

            ST_SHIFT: begin
                if (sclk) begin
                    // Falling edge: DAC samples din; count it.
                    sclk_d  = 1'b0;
                    timer_d = timer + TIMER_ONE;
                end else if (timer == LAST_EDGE) begin
                    state_d  = ST_SYNC_HIGH;
                    timer_d  = '0;
                    sync_n_d = 1'b1;
                    sclk_d   = 1'b1;
                    din_d    = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    // Rising edge: din only moves here, so it is stable across the next fall.
                    sclk_d  = 1'b1;
                    din_d   = shift_reg[FRAME_BITS-2];
                    shift_d = shift_reg << 1;
                end
            end

            ST_SYNC_HIGH: begin
                if (timer == LAST_GUARD) begin
                    state_d       = ST_IDLE;
                    timer_d       = '0;
                    read_enable_d = enable && !fifo_empty;
                end else begin
                    timer_d = timer + TIMER_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                timer_d  = '0;
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                din_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            // NOTE: the shift register is a plain register file of one word,
            // so it is cleared with the rest rather than left unreset.
            shift_reg        <= '0;
            timer            <= '0;
            fifo_read_enable <= 1'b0;
            dac_write_done   <= 1'b0;
            dac_busy         <= 1'b0;
            sclk             <= 1'b1;
            sync_n           <= 1'b1;
            din              <= 1'b0;
        end else begin
            state            <= state_d;
            shift_reg        <= shift_d;
            timer            <= timer_d;
            fifo_read_enable <= read_enable_d;
            dac_write_done   <= done_d;
            dac_busy         <= busy_d;
            sclk             <= sclk_d;
            sync_n           <= sync_n_d;
            din              <= din_d;
        end
    end

endmodule
